// File: rtl/ray_pixel_sequencer_if.sv
// ---------------------------------------------------------------------------
// ray_pixel_sequencer_if
//
// Purpose:
//   Bundles the sequencer's control, core-facing and framebuffer-facing
//   signals. The sequencer binds the master modport. The environment binds
//   the slave modport: this is the frame controller, the intersection core
//   and the framebuffer writer.
//
// Signals:
//   start          frame start request (single-cycle or level)
//   stall          pause issuing new pixels (framebuffer busy)
//   pixel          ray direction to the intersection core (Pixel_s)
//   less_than_zero core result, discriminant < 0 (miss)
//   res_valid      result strobe for res_col/res_row/res_hit
//   res_col        column of the reported result
//   res_row        row of the reported result
//   res_hit        ray hit the sphere (valid with res_valid)
//   busy           frame in progress (SCAN or DRAIN)
//   frame_done     one-cycle pulse, last pixel of the frame reported
//   hit_count      hits in the current/last frame (0 unless the counter is built)
// ---------------------------------------------------------------------------
interface ray_pixel_sequencer_if;

  // Signed ray direction. The widths cover the default 640x480 screen
  // (x -320..319, y 240..-239) and a 0..31 focal depth.
  typedef struct packed {
    logic signed [9:0] x;
    logic signed [9:0] y;
    logic signed [5:0] z;
  } Pixel_s;

  logic        start;
  logic        stall;
  Pixel_s      pixel;
  logic        less_than_zero;
  logic        res_valid;
  logic [9:0]  res_col;
  logic [8:0]  res_row;
  logic        res_hit;
  logic        busy;
  logic        frame_done;
  logic [18:0] hit_count;

  modport master (
    input  start, stall, less_than_zero,
    output pixel, res_valid, res_col, res_row, res_hit,
           busy, frame_done, hit_count
  );

  modport slave (
    output start, stall, less_than_zero,
    input  pixel, res_valid, res_col, res_row, res_hit,
           busy, frame_done, hit_count
  );

endinterface

// File: rtl/ray_pixel_sequencer.sv
// ---------------------------------------------------------------------------
// ray_pixel_sequencer
//
// Purpose:
//   Frame-level scan engine for the sphere-intersection core. It walks every
//   pixel in raster order and registers a ray direction (x, y, z) per issued
//   pixel. It then lines the core's fixed-latency less_than_zero result back
//   up with that pixel's column/row through a tag shift register. Each
//   result is reported as a hit/miss strobe for the framebuffer writer.
//
// Parameters:
//   H_RES        horizontal pixels per line (even, <= 1024)
//   V_RES        lines per frame (even, <= 512)
//   FOCAL_Z      constant z component of every ray (0..31)
//   CORE_LATENCY cycles from a pixel change to the matching core result
//
// Ports:
//   clk   clock
//   rstn  synchronous active-low reset
//   bus   ray_pixel_sequencer_if.master (start, stall, pixel,
//         less_than_zero, res_valid, res_col, res_row, res_hit, busy,
//         frame_done, hit_count)
//
// Optional feature:
//   RAY_SEQ_HIT_COUNT_EN - when defined, hit_count is a saturating 19-bit
//   count of hits. It clears when a start is accepted. When undefined,
//   hit_count is tied to 0.
// ---------------------------------------------------------------------------
module ray_pixel_sequencer #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int FOCAL_Z      = 31,
  parameter int CORE_LATENCY = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  ray_pixel_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [9:0] col;
  logic [8:0] row;
  logic [7:0] drain_cnt;

  logic accept_start;
  logic issue;
  logic last_pixel;
  logic busy_c;
  logic frame_done_c;

  logic [9:0] x_calc;
  logic [9:0] y_calc;

  logic signed [9:0] px_x;
  logic signed [9:0] px_y;
  logic signed [5:0] px_z;

  // Stage 0 loads on the same edge as the pixel register. Stage
  // CORE_LATENCY is therefore visible exactly CORE_LATENCY cycles later,
  // in the cycle where the core's answer for that pixel appears.
  logic       tag_valid [0:CORE_LATENCY];
  logic [9:0] tag_col   [0:CORE_LATENCY];
  logic [8:0] tag_row   [0:CORE_LATENCY];

  logic res_valid_c;
  logic res_hit_c;

  assign accept_start = (state == IDLE) && bus.start;
  assign issue        = (state == SCAN) && !bus.stall;
  assign last_pixel   = (col == 10'(H_RES - 1)) && (row == 9'(V_RES - 1));

  // Modular 10-bit arithmetic already yields the correct two's-complement
  // ray component for every on-screen coordinate.
  assign x_calc = col - 10'(H_RES / 2);
  assign y_calc = 10'(V_RES / 2) - {1'b0, row};

  // Next-state and status decode. frame_done fires in the last DRAIN cycle.
  // That is the cycle where the final pixel's tag reaches the output stage.
  always_comb begin
    state_next   = state;
    busy_c       = 1'b0;
    frame_done_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        busy_c = 1'b1;
        if (issue && last_pixel) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy_c = 1'b1;
        if (drain_cnt == 8'(CORE_LATENCY)) begin
          frame_done_c = 1'b1;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Raster position. It advances on every issue and wraps at the end of
  // each line. After the final pixel it returns to the origin.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      col <= '0;
      row <= '0;
    end else if (accept_start) begin
      col <= '0;
      row <= '0;
    end else if (issue) begin
      if (col == 10'(H_RES - 1)) begin
        col <= '0;
        row <= last_pixel ? 9'd0 : row + 9'd1;
      end else begin
        col <= col + 10'd1;
      end
    end
  end

  // DRAIN cycle counter. It reads 0 in the first DRAIN cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + 8'd1;
    end else begin
      drain_cnt <= '0;
    end
  end

  // Ray direction register. It holds its value whenever no pixel is issued.
  // The core keeps evaluating the stale ray, but the tag pipeline marks
  // that slot as a bubble.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      px_x <= '0;
      px_y <= '0;
      px_z <= '0;
    end else if (issue) begin
      px_x <= $signed(x_calc);
      px_y <= $signed(y_calc);
      px_z <= 6'(FOCAL_Z);
    end
  end

  // Tag pipeline. It shifts every cycle so that its delay stays locked to
  // the core's fixed latency even while issuing is stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i <= CORE_LATENCY; i++) begin
        tag_valid[i] <= 1'b0;
        tag_col[i]   <= '0;
        tag_row[i]   <= '0;
      end
    end else begin
      tag_valid[0] <= issue;
      tag_col[0]   <= col;
      tag_row[0]   <= row;
      for (int i = 1; i <= CORE_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_col[i]   <= tag_col[i-1];
        tag_row[i]   <= tag_row[i-1];
      end
    end
  end

  assign res_valid_c = tag_valid[CORE_LATENCY];

  // Gated with res_valid so the output reads 0 outside result strobes.
  assign res_hit_c = res_valid_c & ~bus.less_than_zero;

  assign bus.pixel      = {px_x, px_y, px_z};
  assign bus.res_valid  = res_valid_c;
  assign bus.res_col    = tag_col[CORE_LATENCY];
  assign bus.res_row    = tag_row[CORE_LATENCY];
  assign bus.res_hit    = res_hit_c;
  assign bus.busy       = busy_c;
  assign bus.frame_done = frame_done_c;

`ifdef RAY_SEQ_HIT_COUNT_EN
  logic [18:0] hit_cnt;

  // Hit counter. It clears on an accepted start and saturates at all-ones.
  // Between frames it keeps the last frame's total.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_cnt <= '0;
    end else if (accept_start) begin
      hit_cnt <= '0;
    end else if (res_hit_c && (hit_cnt != 19'h7FFFF)) begin
      hit_cnt <= hit_cnt + 19'd1;
    end
  end

  assign bus.hit_count = hit_cnt;
`else
  assign bus.hit_count = '0;
`endif

endmodule

// File: tb/tb_ray_pixel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ray_pixel_sequencer
//
// Purpose:
//   Directed bench for ray_pixel_sequencer on a 4x2 screen. The core is
//   modelled as a CORE_LATENCY-deep delay of (pixel.x < 0). Pixels in
//   columns 2 and 3 (x >= 0) therefore report hits, and all others report
//   misses. Honours RAY_SEQ_HIT_COUNT_EN for the expected hit_count.
// ---------------------------------------------------------------------------
module tb_ray_pixel_sequencer;

  localparam int H   = 4;
  localparam int V   = 2;
  localparam int FZ  = 31;
  localparam int LAT = 5;

`ifdef RAY_SEQ_HIT_COUNT_EN
  localparam int EXP_HITS = 4;
`else
  localparam int EXP_HITS = 0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic model_en;
  logic lt_force;
  logic [LAT-1:0] core_dly = '0;

  int tests_run    = 0;
  int tests_failed = 0;

  ray_pixel_sequencer_if bus();

  ray_pixel_sequencer #(
    .H_RES(H),
    .V_RES(V),
    .FOCAL_Z(FZ),
    .CORE_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Core model: the result follows a pixel change by LAT edges.
  always @(posedge clk) begin
    core_dly <= {core_dly[LAT-2:0], (bus.pixel.x < 0)};
  end

  assign bus.less_than_zero = model_en ? core_dly[LAT-1] : lt_force;

  function automatic int px_x();
    return int'(bus.pixel.x);
  endfunction

  function automatic int px_y();
    return int'(bus.pixel.y);
  endfunction

  function automatic int px_z();
    return int'(bus.pixel.z);
  endfunction

  task automatic test_reset();
    logic [67:0] all_out;
    rstn     = 1'b0;
    model_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.stall = 1'($urandom_range(0, 1));
      lt_force  = 1'($urandom_range(0, 1));
      @(negedge clk);
      all_out = {bus.pixel, bus.res_valid, bus.res_col, bus.res_row, bus.res_hit,
                 bus.busy, bus.frame_done, bus.hit_count};
      tests_run++;
      if (all_out !== 68'h0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs cycle=%0d got %h expected 0", i, all_out);
      end
    end
    bus.start = 1'b1;
    bus.stall = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_start_ignored got busy=%b expected 0", bus.busy);
    end
    bus.start = 1'b0;
    rstn      = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_idle got busy=%b expected 0", bus.busy);
    end
    lt_force = 1'b0;
    model_en = 1'b1;
  endtask

  task automatic test_scan();
    int k, r, exp_x, exp_y;
    bit exp_v;
    bus.stall = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL scan_enter got busy=%b res_valid=%b expected 1 0", bus.busy, bus.res_valid);
    end
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      k     = (c <= 8) ? c - 1 : 7;
      exp_x = (k % H) - H / 2;
      exp_y = V / 2 - (k / H);
      tests_run++;
      if (px_x() != exp_x || px_y() != exp_y || px_z() != FZ) begin
        tests_failed++;
        $display("[TB] FAIL scan_pixel c=%0d got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                 c, px_x(), px_y(), px_z(), exp_x, exp_y, FZ);
      end
      exp_v = (c >= 6) && (c <= 13);
      tests_run++;
      if (bus.res_valid !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL scan_res_valid c=%0d got %b expected %b", c, bus.res_valid, exp_v);
      end
      if (exp_v) begin
        r = c - 6;
        tests_run++;
        if (bus.res_col !== 10'(r % H) || bus.res_row !== 9'(r / H)) begin
          tests_failed++;
          $display("[TB] FAIL scan_res_pos c=%0d got col=%0d row=%0d expected col=%0d row=%0d",
                   c, bus.res_col, bus.res_row, r % H, r / H);
        end
        tests_run++;
        if (bus.res_hit !== ((r % H) >= 2)) begin
          tests_failed++;
          $display("[TB] FAIL scan_res_hit c=%0d col=%0d got %b expected %b",
                   c, r % H, bus.res_hit, ((r % H) >= 2));
        end
      end
      tests_run++;
      if (bus.frame_done !== (c == 13) || bus.busy !== (c <= 13)) begin
        tests_failed++;
        $display("[TB] FAIL scan_status c=%0d got frame_done=%b busy=%b expected %b %b",
                 c, bus.frame_done, bus.busy, (c == 13), (c <= 13));
      end
      // A start request raised while frame_done is high must not begin a new frame.
      bus.start = (c == 13);
    end
  endtask

  task automatic test_stall();
    int k, r, exp_x, exp_y;
    bit exp_v;
    bus.stall = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c < 2)      k = c - 1;
      else if (c < 6) k = 1;
      else            k = (c - 4 > 7) ? 7 : c - 4;
      exp_x = (k % H) - H / 2;
      exp_y = V / 2 - (k / H);
      tests_run++;
      if (px_x() != exp_x || px_y() != exp_y) begin
        tests_failed++;
        $display("[TB] FAIL stall_pixel c=%0d got (%0d,%0d) expected (%0d,%0d)",
                 c, px_x(), px_y(), exp_x, exp_y);
      end
      exp_v = 1'b0;
      r     = 0;
      for (int j = 0; j < 8; j++) begin
        if (((j < 2) ? j + 1 : j + 4) + 5 == c) begin
          exp_v = 1'b1;
          r     = j;
        end
      end
      tests_run++;
      if (bus.res_valid !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL stall_res_valid c=%0d got %b expected %b", c, bus.res_valid, exp_v);
      end
      if (exp_v) begin
        tests_run++;
        if (bus.res_col !== 10'(r % H) || bus.res_row !== 9'(r / H) ||
            bus.res_hit !== ((r % H) >= 2)) begin
          tests_failed++;
          $display("[TB] FAIL stall_result c=%0d got col=%0d row=%0d hit=%b expected col=%0d row=%0d hit=%b",
                   c, bus.res_col, bus.res_row, bus.res_hit, r % H, r / H, ((r % H) >= 2));
        end
      end
      tests_run++;
      if (bus.frame_done !== (c == 16) || bus.busy !== (c <= 16)) begin
        tests_failed++;
        $display("[TB] FAIL stall_status c=%0d got frame_done=%b busy=%b expected %b %b",
                 c, bus.frame_done, bus.busy, (c == 16), (c <= 16));
      end
      if (c == 2) bus.stall = 1'b1;
      if (c == 5) bus.stall = 1'b0;
      // A start request raised mid-scan must be ignored.
      bus.start = (c == 3);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    bus.stall = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 3; c++) @(negedge clk);
    tests_run++;
    if (px_x() != 0 || px_y() != 1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_before got (%0d,%0d) expected (0,1)", px_x(), px_y());
    end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tests_run++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pixel !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_clear got res_valid=%b busy=%b pixel=%h expected 0 0 0",
               bus.res_valid, bus.busy, bus.pixel);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.res_valid, bus.frame_done, bus.busy} !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL midrst_quiet i=%0d got valid/done/busy=%b expected 000",
                 i, {bus.res_valid, bus.frame_done, bus.busy});
      end
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (px_x() != -2 || px_y() != 1 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_restart got (%0d,%0d) busy=%b expected (-2,1) busy=1",
               px_x(), px_y(), bus.busy);
    end
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (bus.frame_done !== 1'b1 || bus.res_col !== 10'd3 || bus.res_row !== 9'd1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_frame_done got done=%b col=%0d row=%0d after %0d cycles expected done=1 col=3 row=1",
               bus.frame_done, bus.res_col, bus.res_row, n);
    end
    @(negedge clk);
  endtask

  task automatic test_hit_count();
    int n;
    bus.stall = 1'b0;
    for (int f = 0; f < 2; f++) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      tests_run++;
      if (bus.hit_count !== 19'd0 || bus.busy !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL hitcnt_clear frame=%0d got count=%0d busy=%b expected 0 1",
                 f, bus.hit_count, bus.busy);
      end
      n = 0;
      while (bus.frame_done !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      tests_run++;
      if (bus.hit_count !== 19'(EXP_HITS) || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL hitcnt_total frame=%0d got count=%0d busy=%b expected %0d 0",
                 f, bus.hit_count, bus.busy, EXP_HITS);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    lt_force  = 1'b0;
    model_en  = 1'b0;
    rstn      = 1'b0;
    test_reset();
    test_scan();
    test_stall();
    test_reset_mid_frame();
    test_hit_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ray_pixel_sequencer.md
Name: ray_pixel_sequencer

Overview:
Frame-level scan engine that drives the sphere-intersection core. It walks every screen pixel in raster order, emits the per-pixel ray direction as Pixel_s, and aligns the core's fixed-latency less_than_zero result back to its pixel coordinates. The result is presented as a hit/miss strobe to the framebuffer writer. The block sits directly upstream of the intersection core and also collects that core's output.

Parameters:
H_RES, 640, horizontal pixels per line (even)
V_RES, 480, lines per frame (even)
FOCAL_Z, 31, constant z component of every ray (0..31)
CORE_LATENCY, 5, cycles from pixel change to the matching less_than_zero update

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start  in  1  frame start request, single-cycle or level
stall  in  1  pause issuing new pixels (framebuffer busy)
pixel  out  Pixel_s  ray direction to core (x,y,z fields as defined in types.sv)
less_than_zero  in  1  core result, discriminant < 0 (miss)
res_valid  out  1  result strobe for res_col/res_row/res_hit
res_col  out  10  column 0..H_RES-1 of result
res_row  out  9  row 0..V_RES-1 of result
res_hit  out  1  ray hit sphere (= ~less_than_zero when res_valid)
busy  out  1  high in SCAN or DRAIN
frame_done  out  1  one-cycle pulse, frame fully reported
hit_count  out  19  hits in current/last frame (see Optional Feature)

Behaviour:
- One clock, synchronous active-low reset. Reset values: all outputs 0, including pixel x/y/z, tag pipeline valids, and counters. State is IDLE.
- States:
  - IDLE: start=1 -> SCAN, with col=0, row=0.
  - SCAN: issues pixels. The issue of col=H_RES-1, row=V_RES-1 -> DRAIN.
  - DRAIN: counts CORE_LATENCY cycles -> IDLE.
- start is ignored while busy=1.
- Issue: in SCAN with stall=0, pixel is registered on that edge to x=col-H_RES/2, y=V_RES/2-row, z=FOCAL_Z, all signed. With defaults: x -320..319, y 240..-239.
- After each issue, col increments. Wrap at H_RES-1 -> col=0, row+1.
- stall=1 or non-SCAN: pixel holds its last value and no issue occurs. Tag pipeline shifts in a bubble, so the core keeps computing but the result is discarded.
- Tag pipeline: {valid,col,row} shift register advances every cycle regardless of stall. res_valid/res_col/res_row assert exactly CORE_LATENCY cycles after the edge that loaded the corresponding pixel.
- res_hit is combinational ~less_than_zero, meaningful only while res_valid=1.
- Results come out in issue order, one per cycle max, with no backpressure. The consumer must accept every strobe.
- frame_done pulses in the same cycle as the final pixel's res_valid. busy drops the next cycle.
- Stall in DRAIN has no effect. Stall on the final pixel delays entry to DRAIN.
- Reset mid-frame: on the reset edge, state->IDLE, all tag valids clear, so res_valid=0 the next cycle. No frame_done is produced for the aborted frame.
- start arriving on the same cycle as frame_done is ignored. A new frame needs start while IDLE.

Optional Feature:
Macro RAY_SEQ_HIT_COUNT_EN.
- Defined: hit_count is a 19-bit counter. It clears on the edge that accepts start and increments on each cycle with res_valid=1 and res_hit=1. It holds its value after frame_done until the next accepted start, and saturates at 2^19-1.
- Not defined: hit_count is tied to 0 and no counter logic exists. The port is always present.

Test Plan:
1. Reset with rstn=0 for 3 cycles, random inputs -> all outputs 0, busy=0; start while rstn=0 is ignored.
2. H_RES=4, V_RES=2, FOCAL_Z=31, stall=0, start pulse -> pixel sequence (x,y) is (-2,1),(-1,1),(0,1),(1,1),(-2,0)...(1,0) with z=31; res_valid is high for 8 consecutive cycles, starting 5 cycles after the first issue; frame_done coincides with res col=3, row=1.
3. Same config, stall=1 for 3 cycles after the 2nd issue -> pixel holds (-1,1); res_valid shows a 3-cycle gap; col/row order is unchanged; frame_done arrives 3 cycles later than in scenario 2.
4. Model the core as a 5-stage delay of (pixel.x<0). Expected: res_hit=1 exactly for col>=2. Any misalignment of one cycle shows up as mismatches at col 1/2.
5. Assert rstn=0 mid-row 0, col 2 -> res_valid=0 the next cycle, no frame_done. A new start then restarts the frame at (-2,1).
6. With RAY_SEQ_HIT_COUNT_EN and the model from scenario 4 -> hit_count=4 at frame_done, cleared to 0 on the next accepted start. Without the macro, hit_count stays 0.
